// File: rtl/tt_bist_harness.sv
// BIST harness: pulses DUT reset, drives LFSR stimulus, folds responses into a MISR, flags pass/fail.
// Optional macro BIST_UIO_CAPTURE_EN folds dut_uio_out into the top byte of each absorbed response.
module tt_bist_harness #(
  parameter int              IN_W         = 8,
  parameter int              OUT_W        = 8,
  parameter int              SIG_W        = 16,
  parameter int              NUM_PATTERNS = 256,
  parameter int              RST_CYCLES   = 4,
  parameter logic [IN_W-1:0] LFSR_SEED    = 8'h01,
  parameter logic [IN_W-1:0] LFSR_TAPS    = 8'hB8,
  parameter logic [SIG_W-1:0] MISR_TAPS   = 16'hB400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [SIG_W-1:0] golden_sig,
  output logic [IN_W-1:0]  dut_ui_in,
  input  logic [OUT_W-1:0] dut_uo_out,
  input  logic [7:0]       dut_uio_out,
  output logic             dut_rst_n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int              RST_W    = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [15:0]     PAT_LAST = 16'(NUM_PATTERNS);
  localparam logic [IN_W-1:0] SEED     = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_DUT,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IN_W-1:0]  r_lfsr;
  logic [IN_W-1:0]  r_ui;
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] r_golden;
  logic [15:0]      r_pat_cnt;
  logic [RST_W-1:0] r_rst_cnt;
  logic             r_dut_rst_n;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [IN_W-1:0]  w_lfsr_next;
  logic [SIG_W-1:0] w_resp;
  logic [SIG_W-1:0] w_sig_next;

  assign w_lfsr_next = {r_lfsr[IN_W-2:0], ^(r_lfsr & LFSR_TAPS)};

`ifdef BIST_UIO_CAPTURE_EN
  assign w_resp = SIG_W'(dut_uo_out) ^ (SIG_W'(dut_uio_out) << (SIG_W - 8));
`else
  logic w_unused_uio;
  assign w_unused_uio = ^dut_uio_out;
  assign w_resp       = SIG_W'(dut_uo_out);
`endif

  assign w_sig_next = (r_sig >> 1) ^ (r_sig[0] ? MISR_TAPS : '0) ^ w_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= SEED;
      r_ui        <= '0;
      r_sig       <= '0;
      r_golden    <= '0;
      r_pat_cnt   <= '0;
      r_rst_cnt   <= '0;
      r_dut_rst_n <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_dut_rst_n <= 1'b1;
          r_ui        <= '0;
          if (start) begin
            r_state     <= S_RESET_DUT;
            r_golden    <= golden_sig;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_sig       <= '0;
            r_lfsr      <= SEED;
            r_pat_cnt   <= '0;
            r_rst_cnt   <= '0;
            r_dut_rst_n <= 1'b0;
          end
        end
        S_RESET_DUT: begin
          r_dut_rst_n <= 1'b0;
          r_ui        <= '0;
          if (r_rst_cnt == RST_LAST) begin
            // Leave reset with the first pattern already on the pins.
            r_state     <= S_RUN;
            r_dut_rst_n <= 1'b1;
            r_ui        <= r_lfsr;
            r_lfsr      <= w_lfsr_next;
            r_pat_cnt   <= 16'd1;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // The response to pattern k is on dut_uo_out while pattern k+1 is driven.
          if (r_pat_cnt != 16'd1) r_sig <= w_sig_next;
          if (r_pat_cnt == PAT_LAST) begin
            r_state <= S_FLUSH;
          end else begin
            r_ui      <= r_lfsr;
            r_lfsr    <= w_lfsr_next;
            r_pat_cnt <= r_pat_cnt + 16'd1;
          end
        end
        S_FLUSH: begin
          r_sig   <= w_sig_next;
          r_pass  <= (w_sig_next == r_golden);
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_ui    <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_ui_in = r_ui;
  assign dut_rst_n = r_dut_rst_n;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Bench for tt_bist_harness: two harness instances (256 and 5 patterns) each wrapped around a loopback DUT.
module tb_tt_bist_harness;

`ifdef BIST_UIO_CAPTURE_EN
  localparam bit UIO_EN = 1'b1;
`else
  localparam bit UIO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, ena, start;
  logic [15:0] golden;
  logic [7:0]  uio;

  logic [7:0]  a_ui, a_uo, b_ui, b_uo;
  logic        a_rst, a_busy, a_done, a_pass;
  logic        b_rst, b_busy, b_done, b_pass;
  logic [15:0] a_sig, b_sig;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tt_bist_harness u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .golden_sig(golden),
    .dut_ui_in(a_ui), .dut_uo_out(a_uo), .dut_uio_out(uio), .dut_rst_n(a_rst),
    .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig)
  );

  tt_bist_harness #(.NUM_PATTERNS(5)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .golden_sig(golden),
    .dut_ui_in(b_ui), .dut_uo_out(b_uo), .dut_uio_out(uio), .dut_rst_n(b_rst),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig)
  );

  // Loopback DUTs: one-cycle register, gated by the shared project enable.
  always @(posedge clk) begin
    if (!a_rst) a_uo <= 8'h00; else if (ena) a_uo <= a_ui;
    if (!b_rst) b_uo <= 8'h00; else if (ena) b_uo <= b_ui;
  end

  function automatic logic [15:0] model(input int n, input bit use_uio);
    logic [7:0]  l;
    logic [15:0] s, r;
    l = 8'h01;
    s = 16'h0000;
    for (int k = 0; k < n; k++) begin
      r = {(use_uio ? 8'hFF : 8'h00), l};
      s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000) ^ r;
      l = {l[6:0], ^(l & 8'hB8)};
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [15:0] g);
    golden = g;
    start  = 1'b1;
    step(1);
    start  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int c;
    c = 0;
    while ((a_busy || b_busy) && c < max_cyc) begin
      step(1);
      c++;
    end
    check("wait_idle_timeout", {31'd0, a_busy | b_busy}, 32'd0);
  endtask

  typedef struct {
    logic       start;
    logic       exp_rst;
    logic [7:0] exp_ui;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[9];

  logic [15:0] m5, m256, m1, m5_plain;
  int          busy_cnt;

  initial begin
    m5       = model(5, UIO_EN);
    m256     = model(256, UIO_EN);
    m1       = model(1, UIO_EN);
    m5_plain = model(5, 1'b0);

    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 8'h01, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 8'h02, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 8'h04, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'h08, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 8'h11, 1'b1};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; golden = 16'h0000; uio = 8'hFF;
    step(2);
    check("rst_ui",   {24'd0, a_ui}, 32'd0);
    check("rst_dutr", {31'd0, a_rst}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_done", {31'd0, a_done}, 32'd0);
    check("rst_pass", {31'd0, a_pass}, 32'd0);
    check("rst_sig",  {16'd0, a_sig}, 32'd0);
    rst_n = 1'b1;
    step(1);
    check("idle_dutr", {31'd0, a_rst}, 32'd1);

    ena = 1'b0; start = 1'b1;
    step(1);
    ena = 1'b1; start = 1'b0;
    step(1);
    check("ena_low_start", {31'd0, a_busy}, 32'd0);

    golden = m5;
    for (int i = 0; i < 9; i++) begin
      start = tbl[i].start;
      step(1);
      start = 1'b0;
      check($sformatf("vec%0d_ui", i),   {24'd0, a_ui}, {24'd0, tbl[i].exp_ui});
      check($sformatf("vec%0d_dutr", i), {31'd0, a_rst}, {31'd0, tbl[i].exp_rst});
      check($sformatf("vec%0d_busy", i), {31'd0, a_busy}, {31'd0, tbl[i].exp_busy});
    end
    busy_cnt = 9;
    while (a_busy && busy_cnt < 400) begin
      step(1);
      if (a_busy) busy_cnt++;
    end
    check("busy_len", busy_cnt, 32'd261);
    check("a_done",   {31'd0, a_done}, 32'd1);
    check("a_sig",    {16'd0, a_sig}, {16'd0, m256});
    check("b_done",   {31'd0, b_done}, 32'd1);
    check("b_pass",   {31'd0, b_pass}, 32'd1);
    check("b_sig",    {16'd0, b_sig}, {16'd0, m5});
    if (UIO_EN) check("uio_differs", {31'd0, b_sig != m5_plain}, 32'd1);

    pulse_start(m5 ^ 16'h0001);
    check("restart_done_clr", {31'd0, b_done}, 32'd0);
    check("restart_busy",     {31'd0, b_busy}, 32'd1);
    wait_idle(400);
    check("wrong_done", {31'd0, b_done}, 32'd1);
    check("wrong_pass", {31'd0, b_pass}, 32'd0);
    check("wrong_sig",  {16'd0, b_sig}, {16'd0, m5});

    pulse_start(m5);
    step(6);
    check("pre_stall_ui",  {24'd0, b_ui}, 32'h04);
    check("pre_stall_sig", {16'd0, b_sig}, {16'd0, m1});
    ena = 1'b0;
    step(10);
    check("stall_ui",   {24'd0, b_ui}, 32'h04);
    check("stall_sig",  {16'd0, b_sig}, {16'd0, m1});
    check("stall_busy", {31'd0, b_busy}, 32'd1);
    ena = 1'b1;
    wait_idle(400);
    check("stall_pass", {31'd0, b_pass}, 32'd1);
    check("stall_sig_final", {16'd0, b_sig}, {16'd0, m5});

    pulse_start(m5);
    step(6);
    rst_n = 1'b0;
    step(1);
    check("midrst_busy", {31'd0, b_busy}, 32'd0);
    check("midrst_sig",  {16'd0, b_sig}, 32'd0);
    check("midrst_ui",   {24'd0, b_ui}, 32'd0);
    check("midrst_done", {31'd0, b_done}, 32'd0);
    rst_n = 1'b1;
    step(1);
    pulse_start(m5);
    wait_idle(400);
    check("rerun_pass", {31'd0, b_pass}, 32'd1);
    check("rerun_sig",  {16'd0, b_sig}, {16'd0, m5});
    check("rerun_a_sig", {16'd0, a_sig}, {16'd0, m256});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_bist_harness.md
Name: tt_bist_harness

Overview:
- Synthesizable, parametrised built-in self-test harness for a Tiny Tapeout user project.
- Sits between the pad ring and a DUT that uses the standard ui_in/uo_out/uio pinout.
- Pulses the DUT reset, then drives the DUT inputs with an LFSR stimulus sequence.
- Compresses DUT responses into a MISR signature and compares that signature against a golden value; the outcome is reported as pass or fail.

Parameters:
- IN_W, 8: width of DUT input bus driven with stimulus.
- OUT_W, 8: width of DUT output bus captured; must be <= SIG_W.
- SIG_W, 16: MISR signature width.
- NUM_PATTERNS, 256: number of stimulus patterns applied; range 1..65535.
- RST_CYCLES, 4: number of cycles dut_rst_n is held low before the run; >= 1.
- LFSR_SEED, 8'h01: initial stimulus LFSR value; an all-zero seed is replaced by 1.
- LFSR_TAPS, 8'hB8: IN_W-bit feedback tap mask.
- MISR_TAPS, 16'hB400: SIG_W-bit Galois feedback mask.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- ena, input, 1: high = harness advances; low = all state frozen.
- start, input, 1: single-cycle request to begin a test.
- golden_sig, input, SIG_W: expected signature; sampled on the cycle start is accepted.
- dut_ui_in, output, IN_W: stimulus to the DUT dedicated inputs.
- dut_uo_out, input, OUT_W: DUT dedicated outputs.
- dut_uio_out, input, 8: DUT bidirectional output path; used only with the optional feature.
- dut_rst_n, output, 1: reset driven to the DUT.
- busy, output, 1: high from start acceptance until done is set.
- done, output, 1: sticky; high once the test has completed.
- pass, output, 1: high when signature == golden_sig; valid only while done = 1.
- signature, output, SIG_W: current MISR contents.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- All outputs are registered.
- Values while rst_n = 0: state = IDLE, dut_ui_in = 0, dut_rst_n = 0, busy = 0, done = 0, pass = 0, signature = 0, LFSR = seed, counters = 0.
- ena = 0: no register changes, so every output holds its value. start is ignored.
- IDLE:
  - dut_rst_n = 1.
  - start = 1 → RESET_DUT. On the same edge: latch golden_sig, set busy = 1, clear done and pass, clear signature to 0, load LFSR = seed, clear counters.
- RESET_DUT:
  - dut_rst_n = 0 and dut_ui_in = 0 for exactly RST_CYCLES cycles, then → RUN.
- RUN:
  - dut_rst_n = 1.
  - Each cycle, dut_ui_in = LFSR and the pattern counter increments.
  - LFSR update: next = {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)}.
  - The MISR absorbs dut_uo_out on every RUN cycle except the first, i.e. each response is captured one cycle after its pattern is applied.
  - After NUM_PATTERNS patterns have been applied → FLUSH.
- FLUSH:
  - Single cycle. dut_ui_in holds the last pattern.
  - The MISR absorbs the final response, for a total of exactly NUM_PATTERNS absorptions.
  - Then → DONE.
- MISR update: sig_next = (sig >> 1) ^ (sig[0] ? MISR_TAPS : 0) ^ zero_extend(response).
- DONE:
  - busy = 0, done = 1.
  - pass = (signature == latched golden).
  - dut_ui_in = 0.
  - start = 1 → RESET_DUT, with the same actions as from IDLE.
- start while busy (RESET_DUT, RUN, FLUSH): ignored. golden_sig changes after acceptance: ignored.
- NUM_PATTERNS = 1: RUN lasts one cycle with no absorption; FLUSH performs the single absorption.
- Reset mid-run: returns to IDLE with reset values; no partial result is retained.
- Counter widths: 16-bit pattern counter; RST counter sized as clog2(RST_CYCLES + 1).

Optional Feature:
- Macro BIST_UIO_CAPTURE_EN.
- Defined: response = dut_uo_out ^ (dut_uio_out << (SIG_W - 8)), i.e. the uio outputs are folded into the top byte of the absorbed word. This requires SIG_W >= 8.
- Undefined: dut_uio_out is unused and response = dut_uo_out only. Signatures differ between the two builds.

Test Plan:
- Default parameters, rst_n held low for 2 cycles and then released → all outputs 0. dut_rst_n rises to 1 on the first IDLE edge.
- Stimulus sequence: start pulse → dut_rst_n low for exactly 4 cycles. Then dut_ui_in = 01, 02, 04, 08, 11 on consecutive cycles. busy stays high for 4 + 256 + 1 cycles, after which done = 1.
- Loopback DUT, bit-accurate golden: DUT is a register, uo_out = ui_in delayed 1 cycle. golden_sig comes from a bench model with NUM_PATTERNS = 5 → pass = 1 and signature matches the model.
- Wrong golden: same run with golden_sig = model ^ 16'h0001 → done = 1, pass = 0.
- Handshake: start re-pulsed mid-RUN → ignored and run length unchanged. ena held low for 10 cycles mid-RUN → dut_ui_in and signature frozen, and the final signature is identical to a run without the stall.
- Reset and restart: rst_n low during RUN → IDLE, busy = 0, signature = 0. A new start then reproduces the golden signature. With BIST_UIO_CAPTURE_EN defined and dut_uio_out = 8'hFF → signature differs from the undefined build and matches the model.
